// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide coprocessor for the execute stage.
// MULTU/MULT use shift-add over a 2*WIDTH product. DIVU/DIV use restoring
// division that produces one quotient bit per clock. Signed operations work
// on operand magnitudes and apply the result signs in a single FIX cycle.
// Results follow MIPS HI/LO semantics.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN
// as soon as the remaining multiplier bits are all zero. Divides never exit
// early in either build.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] porta,
  input  logic [WIDTH-1:0] portb,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_r;       // op[1]: divide, op[0]: signed
  logic               neg_q;      // quotient / product is negative
  logic               neg_r;      // remainder is negative
  logic [2*WIDTH-1:0] mcand;      // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   opb;        // multiplier (shifted right) or divisor

  // Two's-complement magnitude when the operand is to be treated as signed.
  // The most-negative value maps to itself, which is correct read unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign sign_a = op[0] & porta[WIDTH-1];
  assign sign_b = op[0] & portb[WIDTH-1];
  assign mag_a  = mag(porta, op[0]);
  assign mag_b  = mag(portb, op[0]);

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  logic [2*WIDTH-1:0] prod_next;
  assign prod_next = {hi, lo} + (opb[0] ? mcand : '0);

  // One restoring-division step: shift the next dividend bit into the
  // remainder, then try subtracting the divisor.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_diff;
  assign rem_sh   = {hi, lo[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb};

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);

  // Control FSM and iterative datapath.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_r    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      mcand   <= '0;
      opb     <= '0;
      hi      <= '0;
      lo      <= '0;
      divzero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_r  <= op;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            cnt   <= CNT_W'(WIDTH);
            if (op[1] && (portb == '0)) begin
              // Divide by zero: skip the iterations and return the raw dividend.
              hi      <= porta;
              lo      <= '1;
              divzero <= 1'b1;
              state   <= S_FIX;
            end else begin
              divzero <= 1'b0;
              opb     <= mag_b;
              hi      <= '0;
              if (op[1]) begin
                lo    <= mag_a;
                mcand <= '0;
              end else begin
                lo    <= '0;
                mcand <= {{WIDTH{1'b0}}, mag_a};
              end
              state <= S_RUN;
            end
          end
        end
        // ---- RUN: one iteration per clock ----
        S_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (op_r[1]) begin
            if (!rem_diff[WIDTH]) begin
              hi <= rem_diff[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= rem_sh[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= prod_next;
            mcand    <= mcand << 1;
            opb      <= opb >> 1;
          end
`ifdef MULDIV_EARLY_OUT_EN
          if ((cnt == CNT_W'(1)) || (!op_r[1] && (opb[WIDTH-1:1] == '0)))
            state <= S_FIX;
`else
          if (cnt == CNT_W'(1))
            state <= S_FIX;
`endif
        end
        // ---- FIX: apply recorded signs to the magnitude result ----
        S_FIX: begin
          if (op_r[0] && !divzero) begin
            if (op_r[1]) begin
              if (neg_q) lo <= -lo;
              if (neg_r) hi <= -hi;
            end else if (neg_q) begin
              {hi, lo} <= -{hi, lo};
            end
          end
          state <= S_DONE;
        end
        // ---- DONE: hold the response until the consumer takes it ----
        default: begin
          if (resp_ready)
            state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
